t09_input_arbiter: RTL and testbench
====================================

T09_INPUT_ARBITER -- requirements
Module: t09_input_arbiter

Interface
REQ-001 SHALL have parameter COOLDOWN, default 8: idle cycles enforced after each accepted command (legal range 0..255).
REQ-002 SHALL have parameter PRIO_MASK, default 4'b0100: request bits that win over round-robin arbitration.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_i  input  4  single-cycle request pulses from the synchronized edge detectors; bit0 jump, bit1 duck, bit2 start, bit3 pause.
REQ-006 SHALL have port cmd_ready_i  input  1  game FSM can accept a command this cycle.
REQ-007 SHALL have port cmd_valid_o  output  1  command offered.
REQ-008 SHALL have port cmd_id_o  output  2  index of the offered request.
REQ-009 SHALL have port pending_o  output  4  current pending-request register.
REQ-010 SHALL have port drop_o  output  1  one-cycle pulse when a request is lost because it was already pending.

Function
REQ-011 SHALL hold a 4-bit pending register; req_i[k]=1 sets pending[k] on the next edge.
REQ-012 SHALL clear pending[k] on an accepted transfer (cmd_valid_o & cmd_ready_i with cmd_id_o==k).
REQ-013 SHALL leave pending[k]=1 when req_i[k] and acceptance of k coincide in the same cycle; the new request is retained and no drop is flagged.
REQ-014 SHALL assert drop_o on the cycle after req_i[k]=1 arrives while pending[k]=1 and k is not being accepted; multiple dropped bits in one cycle yield a single pulse.
REQ-015 SHALL implement FSM states IDLE, OFFER, COOL.
REQ-016 SHALL, in IDLE with pending!=0, select a winner, register it into cmd_id_o and enter OFFER on the next edge.
REQ-017 SHALL select the winner as follows: if (pending & PRIO_MASK)!=0, the lowest such index; otherwise round-robin over pending starting at index (ptr+1) mod 4.
REQ-018 SHALL hold a 2-bit pointer ptr, updated to cmd_id_o on each accepted transfer and otherwise unchanged.
REQ-019 SHALL drive cmd_valid_o=1 only in OFFER.
REQ-020 SHALL hold cmd_id_o stable throughout OFFER until acceptance; requests arriving during OFFER never change the offered id.
REQ-021 SHALL, in OFFER with cmd_ready_i=1, go to COOL loading counter=COOLDOWN-1, or go directly to IDLE when COOLDOWN==0.
REQ-022 SHALL, in COOL, decrement the counter each cycle and enter IDLE when counter==0 (exactly COOLDOWN cycles in COOL).
REQ-023 SHALL continue accepting requests into pending in all states.
REQ-024 SHALL produce first cmd_valid_o two cycles after a req_i pulse reaches an IDLE arbiter with empty pending (pulse at edge t, valid from edge t+2).
REQ-025 SHALL keep cmd_valid_o deasserted while cmd_ready_i is ignored in IDLE and COOL.

Reset
REQ-026 SHALL, while rst_i=1, force state IDLE, pending=0, ptr=3, counter=0, cmd_id_o=0, cmd_valid_o=0, drop_o=0, regardless of clk.
REQ-027 SHALL, on reset asserted mid-OFFER or mid-COOL, abort immediately with no transfer; requests during reset are discarded.
REQ-028 SHALL resume normal operation on the first rising edge after rst_i deasserts.

Verification
REQ-029 SHALL verify: req_i=4'b0001 pulse at cycle 0, cmd_ready_i=1 -> cmd_valid_o=1, cmd_id_o=0 at cycle 2; pending_o=0 at cycle 3; COOL for 8 cycles.
REQ-030 SHALL verify: req_i=4'b1011 in one cycle, ready=1, COOLDOWN=0 -> grants in order 0,1,3, then cmd_valid_o=0.
REQ-031 SHALL verify: pending=4'b1011 then req_i[2] pulse -> id 2 granted next regardless of ptr.
REQ-032 SHALL verify: cmd_ready_i=0 for 10 cycles in OFFER with further pulses on other bits -> cmd_id_o unchanged; repeat pulse on the offered bit -> drop_o=1 one cycle.
REQ-033 SHALL verify: req_i[1] pulse in the same cycle as acceptance of id 1 -> pending_o[1]=1 afterwards, drop_o=0.
REQ-034 SHALL verify: rst_i asserted mid-COOL and asynchronously between edges -> all outputs 0 immediately; first grant after release is index 0.

Source files
------------

// File: rtl/t09_input_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : t09_input_arbiter_if
// Description : Bundles the request and command signals of the input arbiter.
//               The arbiter connects through "slave". A request source or
//               command consumer (game FSM, bench) connects through "master".
//   req_i       [3:0] request pulses (jump, duck, start, pause)
//   cmd_ready_i       consumer can take a command this cycle
//   cmd_valid_o       command offered
//   cmd_id_o    [1:0] index of the offered request
//   pending_o   [3:0] pending-request register
//   drop_o            one-cycle pulse when a request was lost
// Revision    : 1.0 - initial release
// ============================================================================
interface t09_input_arbiter_if;
    logic [3:0] req_i;
    logic       cmd_ready_i;
    logic       cmd_valid_o;
    logic [1:0] cmd_id_o;
    logic [3:0] pending_o;
    logic       drop_o;

    modport slave (
        input  req_i,
        input  cmd_ready_i,
        output cmd_valid_o,
        output cmd_id_o,
        output pending_o,
        output drop_o
    );

    modport master (
        output req_i,
        output cmd_ready_i,
        input  cmd_valid_o,
        input  cmd_id_o,
        input  pending_o,
        input  drop_o
    );
endinterface
`default_nettype wire

// File: rtl/t09_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : t09_input_arbiter
// Description : Collects single-cycle input request pulses into a pending
//               register. It offers one request at a time to the game FSM
//               through a valid/ready handshake. Bits in PRIO_MASK win
//               outright; the other bits share a round-robin scheme. After
//               each accepted command the arbiter rests for COOLDOWN cycles.
//   clk    : sole clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : t09_input_arbiter_if.slave (req_i, cmd_ready_i, cmd_valid_o,
//            cmd_id_o, pending_o, drop_o)
// Revision    : 1.0 - initial release
// ============================================================================
module t09_input_arbiter #(
    parameter int         COOLDOWN  = 8,
    parameter logic [3:0] PRIO_MASK = 4'b0100
) (
    input  wire logic          clk,
    input  wire logic          rst_i,
    t09_input_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    // The counter is loaded with COOLDOWN-1 so that COOL lasts exactly
    // COOLDOWN cycles, including the cycle in which it reaches zero.
    localparam logic [7:0] c_COOL_LOAD = (COOLDOWN == 0) ? 8'd0 : 8'(COOLDOWN - 1);
    localparam bit         c_NO_COOL   = (COOLDOWN == 0);

    state_t     r_state;
    logic [3:0] r_pending;
    logic [1:0] r_ptr;
    logic [7:0] r_count;
    logic [1:0] r_cmd_id;
    logic       r_cmd_valid;
    logic       r_drop;

    logic       w_accept;
    logic [3:0] w_accept_mask;
    logic [3:0] w_prio;
    logic [1:0] w_winner;
    logic [1:0] w_cand;

    assign w_accept      = r_cmd_valid & bus.cmd_ready_i;
    assign w_accept_mask = w_accept ? (4'b0001 << r_cmd_id) : 4'b0000;
    assign w_prio        = r_pending & PRIO_MASK;

    // Winner selection. The loops run from the far end toward the near end,
    // so the last hit is the one that wins: the lowest priority index, or
    // the first pending bit after ptr (ptr itself is tried last).
    always_comb begin
        w_winner = r_ptr;
        w_cand   = r_ptr;
        if (w_prio != 4'b0000) begin
            for (int i = 3; i >= 0; i--) begin
                if (w_prio[i]) begin
                    w_winner = 2'(i);
                end
            end
        end else begin
            for (int i = 4; i >= 1; i--) begin
                w_cand = r_ptr + 2'(i);
                if (r_pending[w_cand]) begin
                    w_winner = w_cand;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_pending   <= 4'b0000;
            r_ptr       <= 2'd3;
            r_count     <= 8'd0;
            r_cmd_id    <= 2'd0;
            r_cmd_valid <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            // When a new pulse coincides with the acceptance of the same bit,
            // the OR below keeps the new request. It does not count as a drop.
            r_pending <= (r_pending & ~w_accept_mask) | bus.req_i;
            r_drop    <= |(bus.req_i & r_pending & ~w_accept_mask);

            case (r_state)
                S_IDLE: begin
                    if (r_pending != 4'b0000) begin
                        r_cmd_id    <= w_winner;
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (bus.cmd_ready_i) begin
                        r_cmd_valid <= 1'b0;
                        r_ptr       <= r_cmd_id;
                        if (c_NO_COOL) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_COOL;
                            r_count <= c_COOL_LOAD;
                        end
                    end
                end
                S_COOL: begin
                    if (r_count == 8'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_valid_o = r_cmd_valid;
    assign bus.cmd_id_o    = r_cmd_id;
    assign bus.pending_o   = r_pending;
    assign bus.drop_o      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_t09_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_t09_input_arbiter
// Description : Self-checking bench for t09_input_arbiter. It instantiates one
//               arbiter with COOLDOWN=8 and one with COOLDOWN=0. Each expected
//               grant id is pushed to a queue when its stimulus is driven. The
//               queue is popped when the DUT completes the transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t09_input_arbiter;

    logic clk = 1'b0;
    logic rst8;
    logic rst0;

    always #5 clk = ~clk;

    t09_input_arbiter_if b8 ();
    t09_input_arbiter_if b0 ();

    t09_input_arbiter #(.COOLDOWN(8), .PRIO_MASK(4'b0100)) dut8 (
        .clk   (clk),
        .rst_i (rst8),
        .bus   (b8.slave)
    );

    t09_input_arbiter #(.COOLDOWN(0), .PRIO_MASK(4'b0100)) dut0 (
        .clk   (clk),
        .rst_i (rst0),
        .bus   (b0.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a completed transfer on the selected DUT
    // (sel=1: COOLDOWN=0 instance) and compare its id with the queue head.
    task automatic wait_grant(input bit sel, input string tag);
        logic [1:0] id;
        bit         got;
        got = 1'b0;
        id  = 2'd0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (sel ? (b0.cmd_valid_o && b0.cmd_ready_i) : (b8.cmd_valid_o && b8.cmd_ready_i)) begin
                id  = sel ? b0.cmd_id_o : b8.cmd_id_o;
                got = 1'b1;
            end
            tick();
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'(got), 32'd1);
        end else if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            check(tag, 32'(id), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int zeros;
        rst8 = 1'b1;
        rst0 = 1'b1;
        b8.req_i = 4'b0000;
        b8.cmd_ready_i = 1'b0;
        b0.req_i = 4'b0000;
        b0.cmd_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs8", {27'd0, b8.cmd_valid_o, b8.cmd_id_o, b8.drop_o, 1'b0}, 32'd0);
        check("reset_pending8", 32'(b8.pending_o), 32'd0);
        check("reset_outputs0", {27'd0, b0.cmd_valid_o, b0.cmd_id_o, b0.drop_o, 1'b0}, 32'd0);
        rst8 = 1'b0;
        rst0 = 1'b0;

        // A: single request, two-cycle latency, 8-cycle cooldown
        b8.cmd_ready_i = 1'b1;
        b8.req_i = 4'b0001;
        exp_q.push_back(0);
        tick();
        b8.req_i = 4'b0000;
        check("a_pending_c1", 32'(b8.pending_o), 32'h1);
        check("a_valid_c1", 32'(b8.cmd_valid_o), 32'd0);
        tick();
        check("a_valid_c2", 32'(b8.cmd_valid_o), 32'd1);
        check("a_id_c2", 32'(b8.cmd_id_o), 32'(exp_q.pop_front()));
        tick();
        check("a_pending_c3", 32'(b8.pending_o), 32'd0);
        check("a_valid_c3", 32'(b8.cmd_valid_o), 32'd0);
        b8.req_i = 4'b0010;
        exp_q.push_back(1);
        zeros = 1;
        tick();
        b8.req_i = 4'b0000;
        while (!b8.cmd_valid_o && zeros < 40) begin
            zeros++;
            tick();
        end
        // 8 COOL cycles plus one IDLE cycle before the next offer
        check("a_cool_gap", 32'(zeros), 32'd9);
        wait_grant(1'b0, "a_grant1");

        // B: COOLDOWN=0, three simultaneous requests
        b0.cmd_ready_i = 1'b1;
        b0.req_i = 4'b1011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        tick();
        b0.req_i = 4'b0000;
        wait_grant(1'b1, "b_grant0");
        wait_grant(1'b1, "b_grant1");
        wait_grant(1'b1, "b_grant3");
        repeat (3) tick();
        check("b_valid_idle", 32'(b0.cmd_valid_o), 32'd0);
        check("b_pending_empty", 32'(b0.pending_o), 32'd0);

        // C: priority bit jumps ahead of round-robin
        b0.cmd_ready_i = 1'b0;
        b0.req_i = 4'b1011;
        tick();
        b0.req_i = 4'b0000;
        tick();
        b0.req_i = 4'b0100;
        tick();
        b0.req_i = 4'b0000;
        check("c_pending", 32'(b0.pending_o), 32'hF);
        check("c_id_held", 32'(b0.cmd_id_o), 32'd0);
        exp_q.push_back(0);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(1);
        b0.cmd_ready_i = 1'b1;
        wait_grant(1'b1, "c_grant0");
        wait_grant(1'b1, "c_grant2");
        wait_grant(1'b1, "c_grant3");
        wait_grant(1'b1, "c_grant1");

        // D: stalled offer holds id; repeat of offered bit drops
        repeat (12) tick();
        b8.cmd_ready_i = 1'b0;
        b8.req_i = 4'b0001;
        tick();
        b8.req_i = 4'b0000;
        tick();
        check("d_valid", 32'(b8.cmd_valid_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            b8.req_i = (i % 3 == 0) ? 4'b1000 : ((i % 3 == 1) ? 4'b0010 : 4'b0000);
            tick();
            b8.req_i = 4'b0000;
            check($sformatf("d_id_stall%0d", i), {29'd0, b8.cmd_valid_o, b8.cmd_id_o}, 32'h4);
        end
        tick();
        check("d_drop_quiet", 32'(b8.drop_o), 32'd0);
        b8.req_i = 4'b0001;
        tick();
        b8.req_i = 4'b0000;
        check("d_drop_pulse", 32'(b8.drop_o), 32'd1);
        tick();
        check("d_drop_end", 32'(b8.drop_o), 32'd0);
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        b8.cmd_ready_i = 1'b1;
        wait_grant(1'b0, "d_grant0");
        wait_grant(1'b0, "d_grant1");
        wait_grant(1'b0, "d_grant3");

        // E: new pulse on the bit being accepted is retained without drop
        b0.cmd_ready_i = 1'b0;
        b0.req_i = 4'b0010;
        tick();
        b0.req_i = 4'b0000;
        tick();
        check("e_offer", {29'd0, b0.cmd_valid_o, b0.cmd_id_o}, 32'h5);
        b0.cmd_ready_i = 1'b1;
        b0.req_i = 4'b0010;
        tick();
        b0.req_i = 4'b0000;
        b0.cmd_ready_i = 1'b0;
        check("e_pending_kept", 32'(b0.pending_o), 32'h2);
        check("e_no_drop", 32'(b0.drop_o), 32'd0);
        exp_q.push_back(1);
        b0.cmd_ready_i = 1'b1;
        wait_grant(1'b1, "e_regrant1");

        // F: asynchronous reset in the middle of COOL
        repeat (12) tick();
        b8.cmd_ready_i = 1'b1;
        b8.req_i = 4'b0100;
        exp_q.push_back(2);
        tick();
        b8.req_i = 4'b0000;
        wait_grant(1'b0, "f_grant2");
        b8.req_i = 4'b0001;
        tick();
        b8.req_i = 4'b0000;
        tick();
        #2;
        rst8 = 1'b1;
        #1;
        check("f_rst_async", {25'd0, b8.cmd_valid_o, b8.cmd_id_o, b8.pending_o, b8.drop_o}, 32'd0);
        b8.req_i = 4'b1111;
        tick();
        tick();
        check("f_rst_req_discard", 32'(b8.pending_o), 32'd0);
        rst8 = 1'b0;
        b8.req_i = 4'b0000;
        tick();
        check("f_post_rst_pending", 32'(b8.pending_o), 32'd0);
        b8.req_i = 4'b1001;
        exp_q.push_back(0);
        exp_q.push_back(3);
        tick();
        b8.req_i = 4'b0000;
        wait_grant(1'b0, "f_first_after_rst");
        wait_grant(1'b0, "f_second_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
